// File: rtl/fsm_seq_monitor_pkg.sv
// Shared types and constants for the state-sequence monitor.
// Holds the default sequence length, code width and FSM encoding.
package fsm_seq_monitor_pkg;

  localparam int NUM_STATES_DEF = 260;
  localparam int STATE_W        = 9;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOST    = 2'd2
  } mon_state_t;

endpackage

// File: rtl/seq_next_check.sv
// Expected-next compare for the monitored state sequence.
// Flags mismatches and the wrap step from the last code to zero.
module seq_next_check
  import fsm_seq_monitor_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF
) (
  input  logic [STATE_W-1:0] prev,
  input  logic [STATE_W-1:0] state_in,
  output logic               mismatch,
  output logic               wrap
);

  localparam logic [STATE_W-1:0] LAST =
    STATE_W'(NUM_STATES - 1);

  logic [STATE_W-1:0] expected;
  logic               out_of_range;

  always_comb begin
    expected = prev + 1'b1;
    if (prev == LAST) begin
      expected = '0;
    end
  end

  assign out_of_range = (state_in > LAST);
  assign mismatch     = (state_in != expected) ||
                        out_of_range;
  assign wrap         = (prev == LAST) &&
                        (state_in == '0);

endmodule

// File: rtl/fsm_seq_monitor.sv
// Monitors an upstream FSM's state sequence, counting laps and
// errors, with a held snapshot released by a consumer ack.
module fsm_seq_monitor
  import fsm_seq_monitor_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_in,
  input  logic               clear,
  input  logic               snap_req,
  input  logic               snap_ack,
  output logic [CNT_W-1:0]   lap_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               err_flag,
  output logic               in_sync,
  output logic               snap_valid,
  output logic [STATE_W-1:0] snap_state,
  output logic [CNT_W-1:0]   snap_lap
);

  mon_state_t         state_q;
  mon_state_t         state_d;
  logic [STATE_W-1:0] prev_q;
  logic [CNT_W-1:0]   lap_q;
  logic [CNT_W-1:0]   lap_d;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   err_d;
  logic               flag_q;
  logic               flag_d;
  logic               sync_q;
  logic               sv_q;
  logic               sv_d;
  logic [STATE_W-1:0] ss_q;
  logic [CNT_W-1:0]   sl_q;
  logic               snap_load;
  logic               mismatch;
  logic               wrap;

  seq_next_check #(
    .NUM_STATES (NUM_STATES)
  ) u_check (
    .prev     (prev_q),
    .state_in (state_in),
    .mismatch (mismatch),
    .wrap     (wrap)
  );

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    err_d   = err_q;
    flag_d  = flag_q;
    if (clear) begin
      state_d = ACQUIRE;
      lap_d   = '0;
      err_d   = '0;
      flag_d  = 1'b0;
    end else begin
      unique case (state_q)
        ACQUIRE: state_d = TRACK;
        TRACK: begin
          if (mismatch) begin
            state_d = LOST;
            flag_d  = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
          end else if (wrap) begin
            lap_d = lap_q + 1'b1;
          end
        end
        LOST: begin
          if (!mismatch) begin
            state_d = TRACK;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // A pending snapshot blocks new requests unless acked this cycle.
  always_comb begin
    snap_load = !clear && snap_req &&
                (!sv_q || snap_ack);
    sv_d      = sv_q;
    if (clear) begin
      sv_d = 1'b0;
    end else if (snap_load) begin
      sv_d = 1'b1;
    end else if (snap_ack) begin
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQUIRE;
      prev_q  <= '0;
      lap_q   <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= state_in;
      lap_q   <= lap_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      sync_q  <= (state_d == TRACK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q <= 1'b0;
      ss_q <= '0;
      sl_q <= '0;
    end else begin
      sv_q <= sv_d;
      if (snap_load) begin
        ss_q <= state_in;
        sl_q <= lap_d;
      end
    end
  end

  assign lap_count  = lap_q;
  assign err_count  = err_q;
  assign err_flag   = flag_q;
  assign in_sync    = sync_q;
  assign snap_valid = sv_q;
  assign snap_state = ss_q;
  assign snap_lap   = sl_q;

endmodule
